// File: rtl/burst_pkg.sv
// Shared definitions for the burst line adaptor.
//   beats_f         : number of memory beats that make up one requester line
//   adaptor_state_t : adaptor FSM states
package burst_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } adaptor_state_t;

  function automatic int beats_f(input int line_w, input int burst_w);
    return line_w / burst_w;
  endfunction

endpackage

// File: rtl/burst_line_adaptor.sv
// burst_line_adaptor
// Memory-side responder for line requests from the eviction controller. A
// LINE_W-bit line transfer is split into LINE_W/BURST_W beats on the memory
// port (beat 0 = line bits [BURST_W-1:0]); completion is a one-cycle resp_o.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   read_i       : line read request (held until resp_o)
//   write_i      : line write request (held until resp_o), wins over read_i
//   address_i    : line address, low offset bits ignored
//   line_i       : write line data
//   line_o       : last fully assembled read line
//   resp_o       : one-cycle completion pulse
//   address_o    : line-aligned burst address
//   read_o       : burst read request to memory
//   write_o      : burst write request to memory
//   burst_o      : write beat data
//   burst_i      : read beat data
//   resp_i       : memory beat strobe, one beat per high cycle
module burst_line_adaptor
  import burst_pkg::*;
#(
  parameter int LINE_W  = 256,
  parameter int BURST_W = 64,
  parameter int ADDR_W  = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               read_i,
  input  logic               write_i,
  input  logic [ADDR_W-1:0]  address_i,
  input  logic [LINE_W-1:0]  line_i,
  output logic [LINE_W-1:0]  line_o,
  output logic               resp_o,
  output logic [ADDR_W-1:0]  address_o,
  output logic               read_o,
  output logic               write_o,
  output logic [BURST_W-1:0] burst_o,
  input  logic [BURST_W-1:0] burst_i,
  input  logic               resp_i
);

  localparam int NBEATS = beats_f(LINE_W, BURST_W);
  localparam int CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  // Byte-offset mask of a line; these address bits are forced to zero.
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(LINE_W / 8 - 1);
  localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(NBEATS - 1);

  adaptor_state_t      state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  // buf_q holds the write line during a write and the partial line during a
  // read, so an aborted read never disturbs line_q.
  logic [LINE_W-1:0]   buf_q, buf_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic [LINE_W-1:0]   assembled;
  int unsigned         slot;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    buf_d     = buf_q;
    line_d    = line_q;
    slot      = 32'(cnt_q) * 32'(BURST_W);
    assembled = buf_q;
    assembled[slot +: BURST_W] = burst_i;

    unique case (state_q)
      IDLE: begin
        if (write_i || read_i) begin
          addr_d  = address_i & ~OFF_MASK;
          cnt_d   = '0;
          state_d = write_i ? WRITE : READ;
          if (write_i) begin
            buf_d = line_i;
          end
        end
      end
      READ: begin
        if (resp_i) begin
          buf_d = assembled;
          if (cnt_q == LAST_BEAT) begin
            line_d  = assembled;
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      WRITE: begin
        if (resp_i) begin
          if (cnt_q == LAST_BEAT) begin
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      DONE: begin
        // Requests are deliberately not sampled here: the requester is still
        // dropping its request in this cycle.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      buf_q   <= '0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      buf_q   <= buf_d;
      line_q  <= line_d;
    end
  end

  assign read_o    = (state_q == READ);
  assign write_o   = (state_q == WRITE);
  assign resp_o    = (state_q == DONE);
  assign address_o = addr_q;
  assign line_o    = line_q;
  assign burst_o   = (state_q == WRITE) ? buf_q[slot +: BURST_W] : '0;

endmodule
